// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the byte-wide RAM/IO port between instruction fetch (4-byte word
//   reads) and the load/store buffer (1/2/4-byte loads and stores). Each request
//   is serialised into byte transactions; read bytes are reassembled
//   little-endian. IO writes (addr[17:16] == IO_HI) wait while the UART TX
//   buffer is full. Under contention grants alternate between the requesters.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global ready; low freezes all state
//   flush               aborts an in-flight or pending fetch (never LSB traffic)
//   if_req/if_addr      fetch request; if_done pulses with if_data valid
//   lsb_req/lsb_we/lsb_addr/lsb_size/lsb_wdata
//                       LSB request; lsb_done pulses with lsb_rdata valid
//   mem_din             RAM read byte, valid one cycle after its address
//   mem_dout/mem_a/mem_wr  RAM write byte, byte address, write enable
//   io_buffer_full      UART TX buffer full
//
// Optional feature: define MEM_ARB_PERF_EN to add saturating counters
//   perf_if_grants, perf_lsb_grants, perf_io_wait_cycles.
//
// All outputs come from registers. mem_wr, if_done and lsb_done are
// additionally ANDed with rdy, so a stall blanks them in the very cycle rdy
// drops. A write byte masked this way never reached the RAM and is re-issued
// after the stall. A done pulse is held in its register and reappears once
// rdy returns.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_we,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [1:0]        lsb_size,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_lsb_grants,
    output logic [31:0]       perf_io_wait_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, WAIT} state_t;

    state_t            state_q, state_d;
    logic              last_if_q, last_if_d;   // last completed grant was fetch
    logic              cur_if_q, cur_if_d;     // current operation belongs to fetch
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        n_q, n_d;               // byte count of current operation
    logic [2:0]        iss_q, iss_d;           // bytes issued
    logic [2:0]        cap_q, cap_d;           // bytes captured (reads)
    logic              v1_q, v1_d;             // address of byte cap is on mem_a
    logic              v2_q, v2_d;             // mem_din holds byte cap
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic              lsb_done_q, lsb_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       lsb_rdata_q, lsb_rdata_d;

    logic              if_cand, lsb_cand, grant_if, grant_lsb;
    logic [ADDR_W-1:0] new_base, byte_addr;
    logic [2:0]        new_n;

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[17:16] == IO_HI;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A requester whose done pulse is showing is finishing, not re-requesting.
    always_comb begin
        if_cand   = if_req & ~if_done_q & ~flush;
        lsb_cand  = lsb_req & ~lsb_done_q;
        grant_if  = rdy && (state_q == IDLE) && if_cand && (!lsb_cand || !last_if_q);
        grant_lsb = rdy && (state_q == IDLE) && lsb_cand && !grant_if;
        new_base  = grant_if ? if_addr : lsb_addr;
        new_n     = grant_if ? 3'd4 : size_bytes(lsb_size);
        byte_addr = base_q + ADDR_W'(iss_q);
    end

    always_comb begin
        state_d     = state_q;
        last_if_d   = last_if_q;
        cur_if_d    = cur_if_q;
        base_d      = base_q;
        n_d         = n_q;
        iss_d       = iss_q;
        cap_d       = cap_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        buf_d       = buf_q;
        wdata_d     = wdata_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;

        if (!rdy) begin
            if_done_d  = if_done_q;
            lsb_done_d = lsb_done_q;
            // Reads restart from the first uncaptured byte: the byte pipeline
            // cannot be trusted across a stall.
            if (state_q == RD) begin
                iss_d = cap_q;
                v1_d  = 1'b0;
                v2_d  = 1'b0;
            end
            // The write byte shown this cycle was masked; issue it again.
            if (mem_wr_q) iss_d = iss_q - 3'd1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_if || grant_lsb) begin
                        cur_if_d = grant_if;
                        base_d   = new_base;
                        n_d      = new_n;
                        wdata_d  = lsb_wdata;
                        buf_d    = '0;
                        cap_d    = '0;
                        v2_d     = 1'b0;
                        if (grant_lsb && lsb_we) begin
                            v1_d = 1'b0;
                            if (is_io(new_base) && io_buffer_full) begin
                                state_d = WAIT;
                                iss_d   = '0;
                            end else begin
                                state_d    = WR;
                                mem_a_d    = new_base;
                                mem_dout_d = lsb_wdata[7:0];
                                mem_wr_d   = 1'b1;
                                iss_d      = 3'd1;
                            end
                        end else begin
                            state_d = RD;
                            mem_a_d = new_base;
                            iss_d   = 3'd1;
                            v1_d    = 1'b1;
                        end
                    end
                end
                RD: begin
                    if (cur_if_q && flush) begin
                        state_d = IDLE;
                        v1_d    = 1'b0;
                        v2_d    = 1'b0;
                    end else begin
                        v2_d = v1_q;
                        if (v2_q) begin
                            buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                            cap_d = cap_q + 3'd1;
                            if (cap_q == n_q - 3'd1) begin
                                state_d   = IDLE;
                                last_if_d = cur_if_q;
                                if (cur_if_q) begin
                                    if_done_d = 1'b1;
                                    if_data_d = buf_d;
                                end else begin
                                    lsb_done_d  = 1'b1;
                                    lsb_rdata_d = buf_d;
                                end
                            end
                        end
                        if (iss_q < n_q) begin
                            mem_a_d = byte_addr;
                            iss_d   = iss_q + 3'd1;
                            v1_d    = 1'b1;
                        end else begin
                            v1_d = 1'b0;
                        end
                    end
                end
                WR, WAIT: begin
                    if (iss_q == n_q) begin
                        state_d    = IDLE;
                        last_if_d  = 1'b0;
                        lsb_done_d = 1'b1;
                    end else if (is_io(byte_addr) && io_buffer_full) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = WR;
                        mem_a_d    = byte_addr;
                        mem_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                        iss_d      = iss_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_if_q   <= 1'b1;
            cur_if_q    <= 1'b0;
            base_q      <= '0;
            n_q         <= '0;
            iss_q       <= '0;
            cap_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            buf_q       <= '0;
            wdata_q     <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_if_q   <= last_if_d;
            cur_if_q    <= cur_if_d;
            base_q      <= base_d;
            n_q         <= n_d;
            iss_q       <= iss_d;
            cap_q       <= cap_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            buf_q       <= buf_d;
            wdata_q     <= wdata_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q & rdy;
    assign if_done   = if_done_q & rdy;
    assign lsb_done  = lsb_done_q & rdy;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_grants      <= '0;
            perf_lsb_grants     <= '0;
            perf_io_wait_cycles <= '0;
        end else begin
            if (grant_if && perf_if_grants != '1)
                perf_if_grants <= perf_if_grants + 32'd1;
            if (grant_lsb && perf_lsb_grants != '1)
                perf_lsb_grants <= perf_lsb_grants + 32'd1;
            if (state_q == WAIT && perf_io_wait_cycles != '1)
                perf_io_wait_cycles <= perf_io_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a synchronous byte RAM model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, rdy, flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req, lsb_we;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ram [0:262143];
    logic [31:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wr_addr_q.push_back(mem_a);
            wr_data_q.push_back(mem_dout);
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got=%b exp=0", if_done); end
        checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL reset_lsb_done got=%b exp=0", lsb_done); end
        checks++; if (if_data !== 32'h0) begin errors++; $display("FAIL reset_if_data got=%h exp=0", if_data); end
        checks++; if (lsb_rdata !== 32'h0) begin errors++; $display("FAIL reset_lsb_rdata got=%h exp=0", lsb_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Fetch at 0x1000: addresses in c+1..c+4, if_done in c+6.
    task automatic test_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                checks++;
                if (mem_a !== 32'h1000 + 32'(k - 1) || mem_wr !== 1'b0) begin
                    errors++; $display("FAIL fetch_addr k=%0d got=%h/%b exp=%h/0", k, mem_a, mem_wr, 32'h1000 + 32'(k - 1));
                end
            end
            if (k < 6) begin
                checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL fetch_early_done k=%0d got=%b exp=0", k, if_done); end
            end else begin
                checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL fetch_done got=%b exp=1", if_done); end
                checks++; if (if_data !== 32'h00100513) begin errors++; $display("FAIL fetch_data got=%h exp=00100513", if_data); end
                if_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // IO byte store held off for 3 cycles by a full UART buffer.
    task automatic test_io_backpressure();
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk);
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_size = 2'd0;
        lsb_wdata = 32'h41; io_buffer_full = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) io_buffer_full = 1'b0;
            if (k <= 3) begin
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_wait_wr k=%0d got=%b exp=0", k, mem_wr); end
            end else if (k == 4) begin
                checks++;
                if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
                    errors++; $display("FAIL io_write got=%b/%h/%h exp=1/00030000/41", mem_wr, mem_a, mem_dout);
                end
                checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL io_early_done got=%b exp=0", lsb_done); end
            end else begin
                checks++; if (lsb_done !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL io_done got=%b/%b exp=1/0", lsb_done, mem_wr); end
                lsb_req = 1'b0; lsb_we = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL io_write_count got=%0d exp=1", wr_addr_q.size()); end
    endtask

    // Both requesters from reset, continuously re-requesting.
    task automatic test_back_to_back();
        logic [3:0] order;
        int         n;
        apply_reset();
        order = '0; n = 0;
        if_req = 1'b1; if_addr = 32'h1000;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h20; lsb_size = 2'd0;
        for (int t = 0; t < 80 && n < 4; t++) begin
            @(negedge clk);
            if (if_done) begin
                order[n] = 1'b1; n++;
                checks++; if (if_data !== 32'h00100513) begin errors++; $display("FAIL b2b_if_data got=%h exp=00100513", if_data); end
            end
            if (lsb_done) begin
                order[n] = 1'b0; n++;
                checks++; if (lsb_rdata !== 32'h000000EF) begin errors++; $display("FAIL b2b_lsb_data got=%h exp=000000ef", lsb_rdata); end
            end
            if (n >= 4) begin if_req = 1'b0; lsb_req = 1'b0; end
        end
        if_req = 1'b0; lsb_req = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL b2b_timeout got=%0d exp=4 completions", n); end
        checks++; if (order !== 4'b1010) begin errors++; $display("FAIL b2b_order got=%b exp=1010 (bit0 first, 1=IF)", order); end
        repeat (2) @(negedge clk);
    endtask

    // Flush during the 2nd fetch byte; pending 2-byte load must then run.
    task automatic test_flush();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1000;
        @(negedge clk);
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h20; lsb_size = 2'd1;
        checks++; if (mem_a !== 32'h1000) begin errors++; $display("FAIL flush_a0 got=%h exp=1000", mem_a); end
        @(negedge clk);
        flush = 1'b1; if_req = 1'b0;
        checks++; if (mem_a !== 32'h1001) begin errors++; $display("FAIL flush_a1 got=%h exp=1001", mem_a); end
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            if (k == 3) flush = 1'b0;
            checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL flush_if_done k=%0d got=%b exp=0", k, if_done); end
            if (k == 3) begin
                checks++; if (mem_a !== 32'h1001) begin errors++; $display("FAIL flush_hold_a got=%h exp=1001", mem_a); end
            end
            if (k == 4 || k == 5) begin
                checks++; if (mem_a !== 32'h20 + 32'(k - 4)) begin errors++; $display("FAIL flush_lsb_a k=%0d got=%h exp=%h", k, mem_a, 32'h20 + 32'(k - 4)); end
            end
            if (k < 7) begin
                checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL flush_lsb_early k=%0d got=%b exp=0", k, lsb_done); end
            end else begin
                checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL flush_lsb_done got=%b exp=1", lsb_done); end
                checks++; if (lsb_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL flush_lsb_data got=%h exp=0000beef", lsb_rdata); end
                lsb_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // 4-byte store with rdy low for 5 cycles after the first byte.
    task automatic test_rdy_stall();
        logic [31:0] wd;
        wd = 32'hDDCCBBAA;
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk);
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h100; lsb_size = 2'd2; lsb_wdata = wd;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h100) begin errors++; $display("FAIL stall_first got=%b/%h exp=1/00000100", mem_wr, mem_a); end
        for (int k = 2; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2) rdy = 1'b0;
            if (k == 7) rdy = 1'b1;
            #1;
            if (k <= 6) begin
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL stall_wr k=%0d got=%b exp=0", k, mem_wr); end
            end
            if (k == 8) begin
                checks++;
                if (mem_wr !== 1'b1 || mem_a !== 32'h101 || mem_dout !== 8'hBB) begin
                    errors++; $display("FAIL stall_resume got=%b/%h/%h exp=1/00000101/bb", mem_wr, mem_a, mem_dout);
                end
            end
            if (k == 11) begin
                checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL stall_done got=%b exp=1", lsb_done); end
                lsb_req = 1'b0; lsb_we = 1'b0;
            end else begin
                checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL stall_early_done k=%0d got=%b exp=0", k, lsb_done); end
            end
        end
        @(negedge clk);
        checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL stall_write_count got=%0d exp=4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 32'h100 + 32'(i) || wr_data_q[i] !== wd[8*i +: 8]) begin
                errors++; $display("FAIL stall_write i=%0d got=%h/%h exp=%h/%h", i, wr_addr_q[i], wr_data_q[i], 32'h100 + 32'(i), wd[8*i +: 8]);
            end
        end
    endtask

    // Asynchronous reset in the middle of a fetch, then a clean fetch.
    task automatic test_reset_mid_read();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1000;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0; if_req = 1'b0;
        #1;
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL arst_mem_a got=%h exp=0", mem_a); end
        checks++; if (if_data !== 32'h0) begin errors++; $display("FAIL arst_if_data got=%h exp=0", if_data); end
        checks++; if (if_done !== 1'b0 || mem_wr !== 1'b0 || lsb_done !== 1'b0) begin errors++; $display("FAIL arst_ctrl got=%b%b%b exp=000", if_done, mem_wr, lsb_done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (mem_a !== 32'h1000) begin errors++; $display("FAIL arst_refetch_a got=%h exp=1000", mem_a); end
            end
            if (k == 6) begin
                checks++;
                if (if_done !== 1'b1 || if_data !== 32'h00100513) begin
                    errors++; $display("FAIL arst_refetch got=%b/%h exp=1/00100513", if_done, if_data);
                end
                if_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h05;
        ram[18'h01002] = 8'h10; ram[18'h01003] = 8'h00;
        ram[18'h00020] = 8'hEF; ram[18'h00021] = 8'hBE; ram[18'h00022] = 8'h99;
        test_reset();
        test_fetch();
        test_io_backpressure();
        test_back_to_back();
        test_flush();
        test_rdy_stall();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
